// File: rtl/trace_pkg.sv
// Shared types and helpers for the light-cycle trace grid engine.
// Owner codes: 0 = empty cell, i+1 = cell owned by player i.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_COMMIT,
        ST_OVER
    } fsm_state_t;

    // Owner value of an unoccupied cell; cast to the engine's owner width at use.
    localparam int CELL_EMPTY = 0;

    function automatic logic in_bounds(input int unsigned x, input int unsigned y,
                                       input int unsigned w, input int unsigned h);
        return (x < w) && (y < h);
    endfunction

endpackage

// File: rtl/trace_collide.sv
// Combinational crash detection for one game tick: wall, trail and head-on checks
// for every live player, evaluated on the latched head set.
module trace_collide
    import trace_pkg::*;
#(
    parameter int GRID_W      = 75,
    parameter int GRID_H      = 75,
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 10
) (
    input  logic [NUM_PLAYERS*COORD_W-1:0] hx,
    input  logic [NUM_PLAYERS*COORD_W-1:0] hy,
    input  logic [NUM_PLAYERS-1:0]         alive,
    input  logic [NUM_PLAYERS-1:0]         occupied,
    output logic [NUM_PLAYERS-1:0]         crash
);

    logic [NUM_PLAYERS-1:0] wall;
    logic [NUM_PLAYERS-1:0] headon;

    always_comb begin
        wall   = '0;
        headon = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            wall[i] = !in_bounds(32'(hx[i*COORD_W +: COORD_W]), 32'(hy[i*COORD_W +: COORD_W]),
                                 GRID_W, GRID_H);
            // Only live opponents count: a dead player's head input is meaningless.
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (j != i && alive[j] &&
                    hx[j*COORD_W +: COORD_W] == hx[i*COORD_W +: COORD_W] &&
                    hy[j*COORD_W +: COORD_W] == hy[i*COORD_W +: COORD_W])
                    headon[i] = 1'b1;
            end
        end
    end

    assign crash = alive & (wall | occupied | headon);

endmodule

// File: rtl/trace_grid_engine.sv
// Sequential light-cycle field owner: accepts one head set per tick, checks collisions
// in CHECK, commits survivors in COMMIT, and serves a registered renderer read port.
module trace_grid_engine
    import trace_pkg::*;
#(
    parameter int GRID_W      = 75,
    parameter int GRID_H      = 75,
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 10,
    localparam int OWN_W      = $clog2(NUM_PLAYERS + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           step_valid,
    output logic                           step_ready,
    input  logic [NUM_PLAYERS*COORD_W-1:0] head_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] head_y,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic                           result_vld,
    output logic                           game_over,
    output logic [OWN_W-1:0]               winner,
    input  logic [COORD_W-1:0]             rd_x,
    input  logic [COORD_W-1:0]             rd_y,
    output logic [OWN_W-1:0]               rd_owner
);

    typedef logic [OWN_W-1:0] owner_t;

    localparam int     CELLS = GRID_W * GRID_H;
    localparam int     IDX_W = $clog2(CELLS);
    localparam owner_t EMPTY = owner_t'(CELL_EMPTY);

    fsm_state_t state, state_nxt;

    owner_t                         grid [CELLS];
    logic [NUM_PLAYERS*COORD_W-1:0] hx_p0, hy_p0;
    logic [NUM_PLAYERS-1:0]         alive_q, alive_nxt, occupied, crash;
    logic                           game_over_q;
    owner_t                         winner_q, winner_nxt;
    owner_t                         rd_q;
    logic                           accept;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return IDX_W'(32'(x) * GRID_H + 32'(y));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        step_ready = 1'b0;
        result_vld = 1'b0;
        case (state)
            ST_RUN: begin
                step_ready = 1'b1;
                if (step_valid)
                    state_nxt = ST_CHECK;
            end
            ST_CHECK:  state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                result_vld = 1'b1;
                state_nxt  = game_over_q ? ST_OVER : ST_RUN;
            end
            default: ;
        endcase
        // A new game always wins, including over a step being accepted this cycle.
        if (start)
            state_nxt = ST_RUN;
    end

    assign accept = step_valid && step_ready;

    // ---- stage p0: head set latched on acceptance ----
    always_ff @(posedge clk) begin
        if (accept) begin
            hx_p0 <= head_x;
            hy_p0 <= head_y;
        end
    end

    always_comb begin
        occupied = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            occupied[i] = in_bounds(32'(hx_p0[i*COORD_W +: COORD_W]),
                                    32'(hy_p0[i*COORD_W +: COORD_W]), GRID_W, GRID_H) &&
                          (grid[cell_idx(hx_p0[i*COORD_W +: COORD_W],
                                         hy_p0[i*COORD_W +: COORD_W])] != EMPTY);
        end
    end

    trace_collide #(
        .GRID_W      (GRID_W),
        .GRID_H      (GRID_H),
        .NUM_PLAYERS (NUM_PLAYERS),
        .COORD_W     (COORD_W)
    ) u_collide (
        .hx       (hx_p0),
        .hy       (hy_p0),
        .alive    (alive_q),
        .occupied (occupied),
        .crash    (crash)
    );

    assign alive_nxt = alive_q & ~crash;

    // Only meaningful when at most one survivor remains.
    always_comb begin
        winner_nxt = EMPTY;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_nxt[i])
                winner_nxt = owner_t'(i + 1);
        end
    end

    // ---- stage p1: outcome registered at CHECK -> COMMIT, visible with result_vld ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alive_q     <= '0;
            game_over_q <= 1'b0;
            winner_q    <= EMPTY;
        end else if (start) begin
            alive_q     <= '1;
            game_over_q <= 1'b0;
            winner_q    <= EMPTY;
        end else if (state == ST_CHECK) begin
            alive_q <= alive_nxt;
            if ($countones(alive_nxt) < 2) begin
                game_over_q <= 1'b1;
                winner_q    <= winner_nxt;
            end
        end
    end

    // ---- stage p2: grid write (seed on start, survivors in COMMIT) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grid <= '{default: EMPTY};
        end else if (start) begin
            grid <= '{default: EMPTY};
            // Descending order so the lowest index owns a shared seed cell.
            for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
                if (in_bounds(32'(head_x[i*COORD_W +: COORD_W]),
                              32'(head_y[i*COORD_W +: COORD_W]), GRID_W, GRID_H))
                    grid[cell_idx(head_x[i*COORD_W +: COORD_W],
                                  head_y[i*COORD_W +: COORD_W])] <= owner_t'(i + 1);
            end
        end else if (state == ST_COMMIT) begin
            // Survivors are in-bounds and pairwise distinct, so these writes never clash.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (alive_q[i])
                    grid[cell_idx(hx_p0[i*COORD_W +: COORD_W],
                                  hy_p0[i*COORD_W +: COORD_W])] <= owner_t'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_q <= EMPTY;
        else if (in_bounds(32'(rd_x), 32'(rd_y), GRID_W, GRID_H))
            rd_q <= grid[cell_idx(rd_x, rd_y)];
        else
            rd_q <= EMPTY;
    end

    assign alive     = alive_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign rd_owner  = rd_q;

endmodule

// File: tb/tb_trace_grid_engine.sv
// Self-checking bench for trace_grid_engine: directed game scenarios plus random games
// compared against an array-based model of the game rules.
module tb_trace_grid_engine;

    localparam int GW = 75;
    localparam int GH = 75;
    localparam int NP = 2;
    localparam int CW = 10;
    localparam int OW = 2;
    localparam int HW = NP * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          step_valid = 1'b0;
    logic          step_ready;
    logic [HW-1:0] head_x = '0;
    logic [HW-1:0] head_y = '0;
    logic [NP-1:0] alive;
    logic          result_vld;
    logic          game_over;
    logic [OW-1:0] winner;
    logic [CW-1:0] rd_x = '0;
    logic [CW-1:0] rd_y = '0;
    logic [OW-1:0] rd_owner;

    always #5 clk = ~clk;

    trace_grid_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .head_x     (head_x),
        .head_y     (head_y),
        .alive      (alive),
        .result_vld (result_vld),
        .game_over  (game_over),
        .winner     (winner),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_owner   (rd_owner)
    );

    int errors = 0;
    int checks = 0;

    // Reference model of the field and game state
    int            grid_m [GW][GH];
    logic [NP-1:0] alive_m;
    logic          over_m;
    int            winner_m;
    int            sx [NP];
    int            sy [NP];

    // Observations from the last step
    logic          o_ready_pre, o_rv_chk, o_rv_cmt, o_rv_after, o_ready_after, o_go;
    logic [NP-1:0] o_alive;
    logic [OW-1:0] o_win, o_rd_after, rv;

    function automatic int exp_cell(input int x, input int y);
        return (x < GW && y < GH) ? grid_m[x][y] : 0;
    endfunction

    task automatic model_clear();
        for (int x = 0; x < GW; x++)
            for (int y = 0; y < GH; y++)
                grid_m[x][y] = 0;
        alive_m  = '0;
        over_m   = 1'b0;
        winner_m = 0;
    endtask

    task automatic model_start();
        model_clear();
        alive_m = '1;
        for (int i = 0; i < NP; i++)
            if (sx[i] < GW && sy[i] < GH && grid_m[sx[i]][sy[i]] == 0)
                grid_m[sx[i]][sy[i]] = i + 1;
    endtask

    task automatic model_step();
        bit crash [NP];
        int n;
        for (int i = 0; i < NP; i++) begin
            crash[i] = 1'b0;
            if (alive_m[i]) begin
                if (sx[i] >= GW || sy[i] >= GH) crash[i] = 1'b1;
                else if (grid_m[sx[i]][sy[i]] != 0) crash[i] = 1'b1;
                for (int j = 0; j < NP; j++)
                    if (j != i && alive_m[j] && sx[j] == sx[i] && sy[j] == sy[i]) crash[i] = 1'b1;
            end
        end
        n = 0;
        for (int i = 0; i < NP; i++) begin
            if (crash[i]) alive_m[i] = 1'b0;
            if (alive_m[i]) begin
                grid_m[sx[i]][sy[i]] = i + 1;
                n++;
                winner_m = i + 1;
            end
        end
        if (n < 2) over_m = 1'b1;
        if (n == 0) winner_m = 0;
        if (n >= 2) winner_m = 0;
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NP; i++) begin
            head_x[i*CW +: CW] = CW'(sx[i]);
            head_y[i*CW +: CW] = CW'(sy[i]);
        end
    endtask

    task automatic do_start();
        drive_heads();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_start();
    endtask

    task automatic do_step();
        drive_heads();
        o_ready_pre = step_ready;
        step_valid  = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0;
        head_x     = HW'($urandom);
        head_y     = HW'($urandom);
        o_rv_chk   = result_vld;
        @(posedge clk); #1;
        o_rv_cmt = result_vld;
        o_alive  = alive;
        o_go     = game_over;
        o_win    = winner;
        @(posedge clk); #1;
        o_rv_after    = result_vld;
        o_ready_after = step_ready;
        o_rd_after    = rd_owner;
        model_step();
    endtask

    task automatic read_cell(input int x, input int y, output logic [OW-1:0] v);
        rd_x = CW'(x);
        rd_y = CW'(y);
        @(posedge clk); #1;
        v = rd_owner;
    endtask

    task automatic test_reset();
        int pulses;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        checks++; if (step_ready !== 1'b0) begin errors++; $display("FAIL reset_step_ready: got %b want 0", step_ready); end
        checks++; if (result_vld !== 1'b0) begin errors++; $display("FAIL reset_result_vld: got %b want 0", result_vld); end
        checks++; if (alive !== 2'b00) begin errors++; $display("FAIL reset_alive: got %b want 00", alive); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        checks++; if (winner !== 2'd0) begin errors++; $display("FAIL reset_winner: got %0d want 0", winner); end
        checks++; if (rd_owner !== 2'd0) begin errors++; $display("FAIL reset_rd_owner: got %0d want 0", rd_owner); end
        rst_n = 1'b1;
        step_valid = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (result_vld === 1'b1) pulses++;
        end
        step_valid = 1'b0;
        checks++; if (pulses != 0) begin errors++; $display("FAIL idle_step_ignored: got %0d pulses want 0", pulses); end
        checks++; if (step_ready !== 1'b0) begin errors++; $display("FAIL idle_step_ready: got %b want 0", step_ready); end
    endtask

    task automatic test_basic();
        sx = '{10, 60}; sy = '{10, 60};
        do_start();
        checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b want 1", step_ready); end
        checks++; if (alive !== 2'b11) begin errors++; $display("FAIL start_alive: got %b want 11", alive); end
        read_cell(10, 10, rv);
        checks++; if (rv !== OW'(exp_cell(10, 10))) begin errors++; $display("FAIL seed_p1: got %0d want %0d", rv, exp_cell(10, 10)); end
        read_cell(60, 60, rv);
        checks++; if (rv !== 2'd2) begin errors++; $display("FAIL seed_p2: got %0d want 2", rv); end
        sx = '{11, 59}; sy = '{10, 60};
        rd_x = 11; rd_y = 10;
        do_step();
        checks++; if (o_ready_pre !== 1'b1) begin errors++; $display("FAIL basic_ready_pre: got %b want 1", o_ready_pre); end
        checks++; if (o_rv_chk !== 1'b0) begin errors++; $display("FAIL basic_rv_T1: got %b want 0", o_rv_chk); end
        checks++; if (o_rv_cmt !== 1'b1) begin errors++; $display("FAIL basic_rv_T2: got %b want 1", o_rv_cmt); end
        checks++; if (o_alive !== alive_m || o_alive !== 2'b11) begin errors++; $display("FAIL basic_alive: got %b want %b", o_alive, alive_m); end
        checks++; if (o_rv_after !== 1'b0) begin errors++; $display("FAIL basic_rv_T3: got %b want 0", o_rv_after); end
        checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL basic_ready_T3: got %b want 1", o_ready_after); end
        checks++; if (o_rd_after !== 2'd0) begin errors++; $display("FAIL rd_same_cycle_old: got %0d want 0", o_rd_after); end
        @(posedge clk); #1;
        checks++; if (rd_owner !== 2'd1) begin errors++; $display("FAIL rd_11_10: got %0d want 1", rd_owner); end
        read_cell(59, 60, rv);
        checks++; if (rv !== OW'(exp_cell(59, 60))) begin errors++; $display("FAIL rd_59_60: got %0d want %0d", rv, exp_cell(59, 60)); end
    endtask

    task automatic test_wall();
        int pulses;
        sx = '{75, 58}; sy = '{10, 60};
        do_step();
        checks++; if (o_alive !== 2'b10 || o_alive !== alive_m) begin errors++; $display("FAIL wall_alive: got %b want 10", o_alive); end
        checks++; if (o_go !== 1'b1) begin errors++; $display("FAIL wall_game_over: got %b want 1", o_go); end
        checks++; if (o_win !== 2'd2) begin errors++; $display("FAIL wall_winner: got %0d want 2", o_win); end
        checks++; if (o_ready_after !== 1'b0) begin errors++; $display("FAIL wall_ready_over: got %b want 0", o_ready_after); end
        step_valid = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (result_vld === 1'b1) pulses++;
        end
        step_valid = 1'b0;
        checks++; if (pulses != 0) begin errors++; $display("FAIL over_step_ignored: got %0d pulses want 0", pulses); end
        checks++; if (alive !== 2'b10) begin errors++; $display("FAIL over_alive_hold: got %b want 10", alive); end
    endtask

    task automatic test_headon();
        sx = '{29, 31}; sy = '{30, 30};
        do_start();
        checks++; if (game_over !== 1'b0 || winner !== 2'd0) begin errors++; $display("FAIL restart_clear: got go=%b win=%0d want 0 0", game_over, winner); end
        sx = '{30, 30}; sy = '{30, 30};
        do_step();
        checks++; if (o_alive !== 2'b00 || o_alive !== alive_m) begin errors++; $display("FAIL headon_alive: got %b want 00", o_alive); end
        checks++; if (o_go !== 1'b1 || o_win !== 2'd0) begin errors++; $display("FAIL headon_result: got go=%b win=%0d want 1 0", o_go, o_win); end
        read_cell(30, 30, rv);
        checks++; if (rv !== 2'd0) begin errors++; $display("FAIL headon_cell: got %0d want 0", rv); end
        read_cell(29, 30, rv);
        checks++; if (rv !== OW'(exp_cell(29, 30))) begin errors++; $display("FAIL headon_trail: got %0d want %0d", rv, exp_cell(29, 30)); end
    endtask

    task automatic test_trail();
        sx = '{10, 12}; sy = '{10, 11};
        do_start();
        sx = '{11, 12}; sy = '{10, 10};
        do_step();
        checks++; if (o_alive !== 2'b11) begin errors++; $display("FAIL trail_step1_alive: got %b want 11", o_alive); end
        sx = '{11, 11}; sy = '{11, 10};
        do_step();
        checks++; if (o_alive !== 2'b01 || o_alive !== alive_m) begin errors++; $display("FAIL trail_alive: got %b want 01", o_alive); end
        checks++; if (o_go !== 1'b1 || o_win !== 2'd1) begin errors++; $display("FAIL trail_result: got go=%b win=%0d want 1 1", o_go, o_win); end
        read_cell(11, 10, rv);
        checks++; if (rv !== 2'd1) begin errors++; $display("FAIL trail_owner_kept: got %0d want 1", rv); end
        read_cell(11, 11, rv);
        checks++; if (rv !== 2'd1) begin errors++; $display("FAIL trail_survivor_commit: got %0d want 1", rv); end
        read_cell(12, 10, rv);
        checks++; if (rv !== OW'(exp_cell(12, 10))) begin errors++; $display("FAIL trail_dead_persist: got %0d want %0d", rv, exp_cell(12, 10)); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        sx = '{5, 20}; sy = '{5, 20};
        do_start();
        sx = '{6, 21}; sy = '{5, 20};
        drive_heads();
        step_valid = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_clear();
        checks++; if (result_vld !== 1'b0) begin errors++; $display("FAIL rstmid_rv: got %b want 0", result_vld); end
        checks++; if (alive !== 2'b00 || step_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state: got alive=%b ready=%b want 00 0", alive, step_ready); end
        rst_n = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (result_vld === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_result: got %0d pulses want 0", pulses); end
        read_cell(5, 5, rv);
        checks++; if (rv !== 2'd0) begin errors++; $display("FAIL rstmid_seed1: got %0d want 0", rv); end
        read_cell(20, 20, rv);
        checks++; if (rv !== 2'd0) begin errors++; $display("FAIL rstmid_seed2: got %0d want 0", rv); end
        read_cell(6, 5, rv);
        checks++; if (rv !== 2'd0) begin errors++; $display("FAIL rstmid_step_cell: got %0d want 0", rv); end
    endtask

    task automatic test_start_in_check();
        sx = '{40, 50}; sy = '{40, 50};
        do_start();
        sx = '{41, 51}; sy = '{40, 50};
        drive_heads();
        step_valid = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0;
        sx = '{2, 3}; sy = '{2, 3};
        drive_heads();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_start();
        checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL sic_ready: got %b want 1", step_ready); end
        checks++; if (alive !== 2'b11 || result_vld !== 1'b0) begin errors++; $display("FAIL sic_state: got alive=%b rv=%b want 11 0", alive, result_vld); end
        @(posedge clk); #1;
        checks++; if (result_vld !== 1'b0) begin errors++; $display("FAIL sic_no_result: got %b want 0", result_vld); end
        read_cell(2, 2, rv);
        checks++; if (rv !== 2'd1) begin errors++; $display("FAIL sic_seed1: got %0d want 1", rv); end
        read_cell(3, 3, rv);
        checks++; if (rv !== 2'd2) begin errors++; $display("FAIL sic_seed2: got %0d want 2", rv); end
        read_cell(41, 40, rv);
        checks++; if (rv !== 2'd0) begin errors++; $display("FAIL sic_discarded: got %0d want 0", rv); end
        read_cell(40, 40, rv);
        checks++; if (rv !== 2'd0) begin errors++; $display("FAIL sic_old_seed: got %0d want 0", rv); end
    endtask

    task automatic test_coincident_seed();
        sx = '{7, 7}; sy = '{8, 8};
        do_start();
        read_cell(7, 8, rv);
        checks++; if (rv !== 2'd1) begin errors++; $display("FAIL coincident_seed: got %0d want 1", rv); end
        checks++; if (alive !== 2'b11) begin errors++; $display("FAIL coincident_alive: got %b want 11", alive); end
        read_cell(80, 8, rv);
        checks++; if (rv !== 2'd0) begin errors++; $display("FAIL rd_out_of_bounds: got %0d want 0", rv); end
    endtask

    task automatic test_random_games();
        int cx [NP];
        int cy [NP];
        int r, d, x, y;
        for (int g = 0; g < 12; g++) begin
            for (int i = 0; i < NP; i++) begin
                sx[i] = $urandom_range(0, GW - 1);
                sy[i] = $urandom_range(0, GH - 1);
            end
            do_start();
            cx = sx; cy = sy;
            for (int s = 0; s < 40 && !over_m; s++) begin
                for (int i = 0; i < NP; i++) begin
                    r = $urandom_range(0, 99);
                    d = $urandom_range(0, 3);
                    if (r < 4) begin
                        sx[i] = $urandom_range(60, 90);
                        sy[i] = $urandom_range(60, 90);
                    end else begin
                        sx[i] = (cx[i] + (d == 0 ? 1 : d == 1 ? -1 : 0)) & 1023;
                        sy[i] = (cy[i] + (d == 2 ? 1 : d == 3 ? -1 : 0)) & 1023;
                    end
                end
                if ($urandom_range(0, 99) < 8) begin
                    sx[1] = sx[0]; sy[1] = sy[0];
                end
                do_step();
                checks++; if (o_rv_cmt !== 1'b1 || o_alive !== alive_m) begin errors++; $display("FAIL rand_alive g%0d s%0d: got rv=%b alive=%b want 1 %b", g, s, o_rv_cmt, o_alive, alive_m); end
                checks++; if (o_go !== over_m || o_win !== OW'(winner_m)) begin errors++; $display("FAIL rand_result g%0d s%0d: got go=%b win=%0d want %b %0d", g, s, o_go, o_win, over_m, winner_m); end
                checks++; if (o_ready_after !== !over_m) begin errors++; $display("FAIL rand_ready g%0d s%0d: got %b want %b", g, s, o_ready_after, !over_m); end
                cx = sx; cy = sy;
                x = ($urandom_range(0, 1) == 1) ? cx[$urandom_range(0, NP - 1)] : $urandom_range(0, 79);
                y = ($urandom_range(0, 1) == 1) ? cy[0] : $urandom_range(0, 79);
                x = x & 1023;
                read_cell(x, y, rv);
                checks++; if (rv !== OW'(exp_cell(x, y))) begin errors++; $display("FAIL rand_read (%0d,%0d): got %0d want %0d", x, y, rv, exp_cell(x, y)); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wall();
        test_headon();
        test_trail();
        test_reset_mid();
        test_start_in_check();
        test_coincident_seed();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
